// File: rtl/proof_mod_addsub_limb.sv
// proof_mod_addsub_limb
// Limb-serial modular adder/subtractor: c = a+b, a-b, -a or 2a (mod p),
// for an odd prime p with W-bit operands. One LW-bit adder is stepped over
// NL = W/LW limbs in two passes. Latency is fixed and does not depend on data.
//
// Handshake: a request is accepted on a rising edge where start_i=1 and
// ready_o=1. Operands, modulus and op are captured on that edge, and inputs
// may change afterwards. done_o pulses for exactly one cycle when the result
// is valid. A request in the done cycle is accepted, so operations can run
// back to back. start_i while ready_o=0 is dropped silently.
//
// Ports:
//   clk_i    rising-edge clock
//   arst_ni  asynchronous active-low reset
//   start_i  request strobe
//   op_i     00 add, 01 sub, 10 neg, 11 double
//   modp_i   modulus p (W bits)
//   data_i   operand a (W bits)
//   datb_i   operand b (W bits), used only by add and sub
//   ready_o  block can accept a request
//   done_o   one-cycle pulse: datc_o and err_o are valid
//   err_o    a used operand was >= p
//   datc_o   result, held until the next done_o
module proof_mod_addsub_limb #(
  parameter int W  = 256,
  parameter int LW = 64
) (
  input  logic         clk_i,
  input  logic         arst_ni,
  input  logic         start_i,
  input  logic [1:0]   op_i,
  input  logic [W-1:0] modp_i,
  input  logic [W-1:0] data_i,
  input  logic [W-1:0] datb_i,
  output logic         ready_o,
  output logic         done_o,
  output logic         err_o,
  output logic [W-1:0] datc_o
);

  localparam int NL = W / LW;
  localparam int KW = (NL > 1) ? $clog2(NL) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NL - 1);

  if (LW < 1 || LW > W || (W % LW) != 0) begin : g_bad_params
    $error("proof_mod_addsub_limb: W must be a multiple of LW and LW <= W");
  end

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_P1   = 2'd1;
  localparam logic [1:0] ST_P2   = 2'd2;
  localparam logic [1:0] ST_FIN  = 2'd3;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_NEG = 2'b10;
  localparam logic [1:0] OP_DBL = 2'b11;

  // FSM state, kept under a stable name for checkers.
  logic [1:0]    state_q;
  logic [KW-1:0] k_q;        // limb index within the current pass
  logic [W-1:0]  x_q;        // first operand of pass 1
  logic [W-1:0]  y_q;        // second operand of pass 1
  logic [W-1:0]  p_q;        // latched modulus
  logic [W-1:0]  s_q;        // pass 1 result: x +/- y mod 2^W
  logic [W-1:0]  t_q;        // pass 2 result: s -/+ p mod 2^W
  logic          c_q;        // carry (add) or borrow (sub) between limbs
  logic          c1_q;       // carry/borrow out of pass 1
  logic          sub_q;      // internal mode: 1 = subtract in pass 1
  logic          err_pend_q; // operand range error seen at accept
  logic [W-1:0]  datc_q;
  logic          err_q;

  logic          accept;
  logic          in_p1;
  logic          pass_sub;
  logic          last_limb;
  int            lo;
  logic [LW-1:0] opa;
  logic [LW-1:0] opb;
  logic [LW-1:0] opb_m;
  logic          cin;
  logic [LW:0]   sum_w;
  logic          c_next;
  logic [W-1:0]  t_full;
  logic          take_t;
  logic          err_at_accept;
  logic [W-1:0]  x_d;
  logic [W-1:0]  y_d;
  logic          sub_d;

  assign ready_o = (state_q == ST_IDLE) || (state_q == ST_FIN);
  assign done_o  = (state_q == ST_FIN);
  assign err_o   = err_q;
  assign datc_o  = datc_q;
  assign accept  = start_i && ready_o;

  // Remap the requested op onto (x, y, mode) and flag out-of-range operands.
  always_comb begin
    x_d           = data_i;
    y_d           = datb_i;
    sub_d         = 1'b0;
    err_at_accept = (data_i >= modp_i);
    case (op_i)
      OP_ADD: begin
        err_at_accept = (data_i >= modp_i) || (datb_i >= modp_i);
      end
      OP_SUB: begin
        sub_d         = 1'b1;
        err_at_accept = (data_i >= modp_i) || (datb_i >= modp_i);
      end
      OP_NEG: begin
        x_d   = '0;
        y_d   = data_i;
        sub_d = 1'b1;
      end
      OP_DBL: begin
        y_d = data_i;
      end
      default: begin
        x_d = data_i;
      end
    endcase
  end

  // Shared limb adder. Pass 1 does x +/- y. Pass 2 does s - p for add modes
  // and s + p for sub modes. c_q always holds the true carry or borrow, so
  // the adder's carry-in/out are inverted when subtracting (a - b = a + ~b + 1).
  always_comb begin
    in_p1     = (state_q == ST_P1);
    last_limb = (k_q == K_LAST);
    lo        = int'(k_q) * LW;
    if (in_p1) begin
      opa      = x_q[lo +: LW];
      opb      = y_q[lo +: LW];
      pass_sub = sub_q;
    end else begin
      opa      = s_q[lo +: LW];
      opb      = p_q[lo +: LW];
      pass_sub = ~sub_q;
    end
    opb_m  = pass_sub ? ~opb : opb;
    cin    = pass_sub ? ~c_q : c_q;
    sum_w  = {1'b0, opa} + {1'b0, opb_m} + {{LW{1'b0}}, cin};
    c_next = pass_sub ? ~sum_w[LW] : sum_w[LW];

    // The top limb of t is still combinational when the result is chosen.
    t_full             = t_q;
    t_full[lo +: LW]   = sum_w[LW-1:0];

    // Add: take s-p if x+y overflowed 2^W or s >= p (no borrow).
    // Sub: add p back only if x-y borrowed.
    if (sub_q) begin
      take_t = c1_q;
    end else begin
      take_t = c1_q | ~c_next;
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q    <= ST_IDLE;
      k_q        <= '0;
      x_q        <= '0;
      y_q        <= '0;
      p_q        <= '0;
      s_q        <= '0;
      t_q        <= '0;
      c_q        <= 1'b0;
      c1_q       <= 1'b0;
      sub_q      <= 1'b0;
      err_pend_q <= 1'b0;
      datc_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_FIN: begin
          if (accept) begin
            state_q    <= ST_P1;
            k_q        <= '0;
            c_q        <= 1'b0;
            c1_q       <= 1'b0;
            x_q        <= x_d;
            y_q        <= y_d;
            p_q        <= modp_i;
            sub_q      <= sub_d;
            err_pend_q <= err_at_accept;
            err_q      <= 1'b0;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_P1: begin
          s_q[lo +: LW] <= sum_w[LW-1:0];
          if (last_limb) begin
            c1_q    <= c_next;
            c_q     <= 1'b0;
            k_q     <= '0;
            state_q <= ST_P2;
          end else begin
            c_q <= c_next;
            k_q <= k_q + KW'(1);
          end
        end
        ST_P2: begin
          t_q[lo +: LW] <= sum_w[LW-1:0];
          if (last_limb) begin
            c_q     <= 1'b0;
            k_q     <= '0;
            datc_q  <= take_t ? t_full : s_q;
            err_q   <= err_pend_q;
            state_q <= ST_FIN;
          end else begin
            c_q <= c_next;
            k_q <= k_q + KW'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
